downsample_arbiter: RTL and testbench
=====================================

Name: downsample_arbiter

Overview:
- Shares one Downsample instance (32x32 frame, 2:1 in x and y, combinational ready/valid path, internal x/y counters) between two pixel streams.
- Grants the downsampler for whole frames only, so its x/y counters stay aligned with frame boundaries.
- Routes the decimated output back to the owning requester.
- Sits between two camera/tile sources and the single downsampler, on the same CLK/RESET.

Parameters:
- DATA_WIDTH, 16, pixel width on every data port.
- FRAME_W, 32, pixels per line; must match the downsampler.
- FRAME_H, 32, lines per frame; must match the downsampler.
- CNT_W, 10, beat counter width = clog2(FRAME_W*FRAME_H).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in0_valid / in1_valid  input  1  requester k has an input pixel.
- in0_data / in1_data  input  DATA_WIDTH  requester k pixel.
- in0_ready / in1_ready  output  1  pixel of requester k accepted this cycle.
- out0_valid / out1_valid  output  1  decimated pixel for requester k.
- out0_data / out1_data  output  DATA_WIDTH  decimated pixel.
- out0_ready / out1_ready  input  1  requester k sink ready.
- ds_in_valid  output  1  to downsampler data_in_valid.
- ds_in_data  output  DATA_WIDTH  to downsampler data_in_data.
- ds_in_ready  input  1  from downsampler data_in_ready.
- ds_out_valid  input  1  from downsampler data_out_valid.
- ds_out_data  input  DATA_WIDTH  from downsampler data_out_data.
- ds_out_ready  output  1  to downsampler data_out_ready.
- grant  output  1  current owner; meaningful only when busy=1.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse, registered, after the last beat of a frame.

Behaviour:
- One clock, CLK. Reset is synchronous, active-high (RESET sampled on the rising edge of CLK).
- Registered state: state{IDLE, BUSY}, grant, last_grant, beat_cnt[CNT_W], frame_done.
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so requester 0 wins first), beat_cnt=0, frame_done=0.
  - With state=IDLE, every ready/valid output is 0 combinationally.
- IDLE:
  - No handshakes pass.
  - If any inK_valid=1, go to BUSY next cycle. grant takes the round-robin winner: the requester other than last_grant if it is valid, else the valid one.
  - If both are idle, stay in IDLE.
  - The arbitration decision costs exactly one bubble cycle per frame.
- BUSY, owner g=grant:
  - ds_in_valid = in_g_valid; ds_in_data = in_g_data.
  - in_g_ready = ds_in_ready; the other in_ready = 0.
  - out_g_valid = ds_out_valid; out_g_data = ds_out_data; ds_out_ready = out_g_ready.
  - The other out_valid = 0; out data may be driven unconditionally.
  - The path is purely combinational; the arbiter adds zero latency.
- Beat counting:
  - An input beat is in_g_valid & ds_in_ready in BUSY; each one increments beat_cnt.
  - On the beat where beat_cnt == FRAME_W*FRAME_H-1: beat_cnt returns to 0, state goes to IDLE, last_grant takes g, and frame_done=1 for the following cycle.
- Non-owner valid is ignored mid-frame; it waits, and its data must be held stable by the source.
- Simultaneous requests in IDLE: alternate strictly. If both requesters stream continuously, frames interleave 0,1,0,1.
- Owner stall (valid low) or sink stall (ready low) mid-frame: hold grant indefinitely; no timeout.
- RESET mid-frame aborts the frame: no frame_done, and last_grant returns to 1. The same RESET must reset the downsampler so its x/y counters realign.
- busy = (state==BUSY).

Decomposition:
- Package downsample_pkg holds:
  - state enum IDLE/BUSY.
  - Constants FRAME_W, FRAME_H, FRAME_PIXELS = FRAME_W*FRAME_H.
  - The clog2 helper for CNT_W.
- One sub-module is natural: rr_arb2, a 2-way round-robin picker (inputs req[1:0] and last; outputs winner and any). It is reusable for later shared-resource arbiters.
- Muxing and the frame counter stay in the top level.

Test Plan:
- Single requester: reset, then in0 streams 1024 pixels with out0_ready=1 → grant=0; 256 out0 beats, carrying inputs at even x and even y; in1_ready and out1_valid stay 0; frame_done pulses once, the cycle after beat 1024.
- Contention: both valid continuously for 3 frames → grant sequence 0,1,0; one idle cycle between frames; each frame is 1024 input beats and 256 output beats to the correct sink.
- Backpressure: out0_ready toggles 1 cycle on, 3 off → accepted only on odd-x/odd-y drop beats or when ready; no beat is lost or duplicated; grant is held until the count reaches 1024.
- Late arrival: in1 raises valid mid-frame of requester 0 → in1_ready=0 until requester 0's frame ends, then grant=1 after one bubble cycle.
- Reset mid-frame: RESET after 500 beats → next cycle busy=0, every ready/valid output 0, frame_done=0; a fresh frame from in1 alone is granted and completes 1024 beats.
- Counter wrap: back-to-back frames from a single requester → beat_cnt returns to 0 at 1023; the second frame's first output is pixel (0,0) of that frame.

Source files
------------

// File: rtl/downsample_pkg.sv
// Shared types and constants for the downsampler arbiter slice.
package downsample_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int FRAME_W      = 32;
  localparam int FRAME_H      = 32;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: prefers the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  assign any_o    = |req_i;
  assign winner_o = req_i[~last_i] ? ~last_i : last_i;

endmodule

// File: rtl/downsample_arbiter.sv
// Shares one 2:1 downsampler between two pixel streams, granting whole frames only
// so the downsampler's x/y counters stay aligned with frame boundaries.
module downsample_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_W    = 32,
  parameter int FRAME_H    = 32,
  parameter int CNT_W      = downsample_pkg::clog2(FRAME_W * FRAME_H)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  output logic                  in1_ready,
  output logic                  out0_valid,
  output logic [DATA_WIDTH-1:0] out0_data,
  input  logic                  out0_ready,
  output logic                  out1_valid,
  output logic [DATA_WIDTH-1:0] out1_data,
  input  logic                  out1_ready,
  output logic                  ds_in_valid,
  output logic [DATA_WIDTH-1:0] ds_in_data,
  input  logic                  ds_in_ready,
  input  logic                  ds_out_valid,
  input  logic [DATA_WIDTH-1:0] ds_out_data,
  output logic                  ds_out_ready,
  output logic                  grant,
  output logic                  busy,
  output logic                  frame_done
);
  import downsample_pkg::*;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_W * FRAME_H - 1);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic busy_w, own_valid, own_out_ready, in_beat, last_beat;
  logic arb_winner, arb_any;

  rr_arb2 u_arb (
    .req_i    ({in1_valid, in0_valid}),
    .last_i   (last_grant_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  assign busy_w        = (state_q == BUSY);
  assign own_valid     = grant_q ? in1_valid : in0_valid;
  assign own_out_ready = grant_q ? out1_ready : out0_ready;
  assign in_beat       = busy_w & own_valid & ds_in_ready;
  assign last_beat     = in_beat & (beat_cnt_q == LAST_BEAT);

  // Zero-latency routing; everything is gated off while IDLE.
  assign ds_in_valid  = busy_w & own_valid;
  assign ds_in_data   = grant_q ? in1_data : in0_data;
  assign in0_ready    = busy_w & ~grant_q & ds_in_ready;
  assign in1_ready    = busy_w & grant_q & ds_in_ready;
  assign out0_valid   = busy_w & ~grant_q & ds_out_valid;
  assign out1_valid   = busy_w & grant_q & ds_out_valid;
  assign out0_data    = ds_out_data;
  assign out1_data    = ds_out_data;
  assign ds_out_ready = busy_w & own_out_ready;

  assign grant      = grant_q;
  assign busy       = busy_w;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          grant_d = arb_winner;
        end
      end
      BUSY: begin
        if (in_beat) begin
          if (last_beat) begin
            beat_cnt_d   = '0;
            state_d      = IDLE;
            last_grant_d = grant_q;
            frame_done_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contested frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_downsample_arbiter.sv
// Bench for downsample_arbiter: behavioural downsampler, random sources, frame-level reference model.
module tb_downsample_arbiter;

  typedef logic [15:0] pq_t[$];

  logic        CLK, RESET;
  logic [1:0]  vld, irdy, ovld, rdy;
  logic [15:0] d [2];
  logic [15:0] odat [2];
  logic        ds_in_valid, ds_in_ready, ds_out_valid, ds_out_ready;
  logic [15:0] ds_in_data, ds_out_data;
  logic        grant, busy, frame_done;

  int   nchk, nfail, cyc, glob_acc, bp_viol, gap;
  int   sent [2];
  int   limit [2];
  int   cnt_irdy [2];
  int   cnt_ovld [2];
  logic [1:0] en, bp, acc;
  logic busy_prev;
  pq_t  in_q [2];
  pq_t  out_q [2];
  int   end_cyc[$], fd_cyc[$], start_cyc[$], grant_log[$];

  downsample_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .in0_valid(vld[0]), .in0_data(d[0]), .in0_ready(irdy[0]),
    .in1_valid(vld[1]), .in1_data(d[1]), .in1_ready(irdy[1]),
    .out0_valid(ovld[0]), .out0_data(odat[0]), .out0_ready(rdy[0]),
    .out1_valid(ovld[1]), .out1_data(odat[1]), .out1_ready(rdy[1]),
    .ds_in_valid(ds_in_valid), .ds_in_data(ds_in_data), .ds_in_ready(ds_in_ready),
    .ds_out_valid(ds_out_valid), .ds_out_data(ds_out_data), .ds_out_ready(ds_out_ready),
    .grant(grant), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural 32x32 2:1 downsampler with combinational ready/valid.
  logic [4:0] dx, dy;
  logic       keep_w;
  always_comb begin
    keep_w       = ~dx[0] & ~dy[0];
    ds_out_valid = ds_in_valid & keep_w;
    ds_out_data  = ds_in_data;
    ds_in_ready  = keep_w ? ds_out_ready : 1'b1;
  end
  always @(posedge CLK) begin
    if (RESET) begin
      dx <= 5'd0;
      dy <= 5'd0;
    end else if (ds_in_valid && ds_in_ready) begin
      dx <= dx + 5'd1;
      if (dx == 5'd31) dy <= dy + 5'd1;
    end
  end

  function automatic pq_t decimate(pq_t src);
    pq_t r;
    foreach (src[i]) begin
      int p;
      p = i % 1024;
      if (((p % 32) % 2 == 0) && ((p / 32) % 2 == 0)) r.push_back(src[i]);
    end
    return r;
  endfunction

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      in_q[k].delete(); out_q[k].delete();
      sent[k] = 0; cnt_irdy[k] = 0; cnt_ovld[k] = 0;
    end
    end_cyc.delete(); fd_cyc.delete(); start_cyc.delete(); grant_log.delete();
    glob_acc = 0; bp_viol = 0; acc = 2'b00;
  endtask

  // Drive sources just after the rising edge, observe handshakes at the falling edge.
  task automatic step();
    @(posedge CLK); #1;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        sent[k]++;
        d[k] = 16'($urandom);
      end
      if (!en[k]) vld[k] = 1'b0;
      else if (!(vld[k] && !acc[k]))
        vld[k] = (sent[k] < limit[k]) && (int'($urandom_range(99)) >= gap);
      rdy[k] = bp[k] ? (cyc % 4 == 0) : 1'b1;
    end
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      acc[k] = vld[k] & irdy[k];
      if (irdy[k]) cnt_irdy[k]++;
      if (ovld[k]) cnt_ovld[k]++;
      if (acc[k]) begin
        int p;
        p = glob_acc % 1024;
        in_q[k].push_back(d[k]);
        if (((p % 32) % 2 == 0) && ((p / 32) % 2 == 0) && !rdy[k]) bp_viol++;
        glob_acc++;
        if (glob_acc % 1024 == 0) end_cyc.push_back(cyc);
      end
      if (ovld[k] && rdy[k]) out_q[k].push_back(odat[k]);
    end
    if (busy && !busy_prev) begin
      start_cyc.push_back(cyc);
      grant_log.push_back(int'(grant));
    end
    busy_prev = busy;
    if (frame_done) fd_cyc.push_back(cyc);
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1; en = 2'b00; bp = 2'b00; gap = 0;
    step(); step();
    RESET = 1'b0;
    clear_logs();
  endtask

  task automatic run_fd(input int n, input int budget);
    for (int i = 0; i < budget && fd_cyc.size() < n; i++) step();
  endtask

  task automatic test_reset();
    RESET = 1'b1; en = 2'b11; limit[0] = 4096; limit[1] = 4096; gap = 0; bp = 2'b00;
    step(); step();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nchk++; if ({irdy, ovld, ds_in_valid, ds_out_ready} !== 6'b0) begin
      nfail++; $display("FAIL reset_handshakes: got %b expected 000000", {irdy, ovld, ds_in_valid, ds_out_ready}); end
    nchk++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    nchk++; if (grant !== 1'b0) begin nfail++; $display("FAIL reset_grant: got %b expected 0", grant); end
    RESET = 1'b0;
    step();
    nchk++; if (busy !== 1'b1 || grant !== 1'b0) begin
      nfail++; $display("FAIL reset_first_grant: got busy=%b grant=%b expected busy=1 grant=0", busy, grant); end
    nchk++; if (irdy !== 2'b01) begin nfail++; $display("FAIL reset_first_ready: got %b expected 01", irdy); end
  endtask

  task automatic test_single();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b01; limit[0] = 1024; limit[1] = 0; gap = 25;
    run_fd(1, 6000);
    repeat (8) step();
    nchk++; if (fd_cyc.size() != 1) begin nfail++; $display("FAIL single_frame_done_count: got %0d expected 1", fd_cyc.size()); end
    nchk++; if (grant_log.size() != 1 || grant_log[0] != 0) begin
      nfail++; $display("FAIL single_grant: got %0d grants, first %0d, expected 1 grant of 0", grant_log.size(), grant_log[0]); end
    nchk++; if (in_q[0].size() != 1024) begin nfail++; $display("FAIL single_in_beats: got %0d expected 1024", in_q[0].size()); end
    nchk++; if (out_q[0].size() != 256) begin nfail++; $display("FAIL single_out_beats: got %0d expected 256", out_q[0].size()); end
    nchk++; if (cnt_irdy[1] != 0 || cnt_ovld[1] != 0) begin
      nfail++; $display("FAIL single_other_idle: got in1_ready=%0d out1_valid=%0d cycles expected 0", cnt_irdy[1], cnt_ovld[1]); end
    if (fd_cyc.size() > 0 && end_cyc.size() > 0) begin
      nchk++; if (fd_cyc[0] != end_cyc[0] + 1) begin
        nfail++; $display("FAIL single_frame_done_time: got cycle %0d expected %0d", fd_cyc[0], end_cyc[0] + 1); end
    end
    exp = decimate(in_q[0]); nbad = 0;
    foreach (exp[i]) if (i < out_q[0].size()) begin
      nchk++;
      if (out_q[0][i] !== exp[i]) begin
        nfail++; nbad++;
        if (nbad < 5) $display("FAIL single_out_data[%0d]: got %h expected %h", i, out_q[0][i], exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b11; limit[0] = 2048; limit[1] = 2048; gap = 0;
    run_fd(3, 8000);
    nchk++; if (fd_cyc.size() != 3) begin nfail++; $display("FAIL cont_frames: got %0d expected 3", fd_cyc.size()); end
    nchk++; if (grant_log.size() < 3 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0) begin
      nfail++; $display("FAIL cont_grant_seq: got %0d,%0d,%0d expected 0,1,0", grant_log[0], grant_log[1], grant_log[2]); end
    if (start_cyc.size() >= 3 && end_cyc.size() >= 2) begin
      nchk++; if (start_cyc[1] != end_cyc[0] + 2 || start_cyc[2] != end_cyc[1] + 2) begin
        nfail++; $display("FAIL cont_bubble: got starts %0d,%0d expected %0d,%0d", start_cyc[1], start_cyc[2], end_cyc[0] + 2, end_cyc[1] + 2); end
    end
    nchk++; if (in_q[0].size() != 2048 || in_q[1].size() != 1024) begin
      nfail++; $display("FAIL cont_in_beats: got %0d/%0d expected 2048/1024", in_q[0].size(), in_q[1].size()); end
    nchk++; if (out_q[0].size() != 512 || out_q[1].size() != 256) begin
      nfail++; $display("FAIL cont_out_beats: got %0d/%0d expected 512/256", out_q[0].size(), out_q[1].size()); end
    for (int k = 0; k < 2; k++) begin
      exp = decimate(in_q[k]); nbad = 0;
      foreach (exp[i]) if (i < out_q[k].size()) begin
        nchk++;
        if (out_q[k][i] !== exp[i]) begin
          nfail++; nbad++;
          if (nbad < 5) $display("FAIL cont_out_data%0d[%0d]: got %h expected %h", k, i, out_q[k][i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b01; limit[0] = 1024; gap = 0; bp = 2'b01;
    run_fd(1, 8000);
    nchk++; if (fd_cyc.size() != 1) begin nfail++; $display("FAIL bp_frames: got %0d expected 1", fd_cyc.size()); end
    nchk++; if (start_cyc.size() != 1) begin nfail++; $display("FAIL bp_grant_held: got %0d grants expected 1", start_cyc.size()); end
    nchk++; if (bp_viol != 0) begin nfail++; $display("FAIL bp_keep_without_ready: got %0d expected 0", bp_viol); end
    nchk++; if (in_q[0].size() != 1024 || out_q[0].size() != 256) begin
      nfail++; $display("FAIL bp_beats: got %0d/%0d expected 1024/256", in_q[0].size(), out_q[0].size()); end
    exp = decimate(in_q[0]); nbad = 0;
    foreach (exp[i]) if (i < out_q[0].size()) begin
      nchk++;
      if (out_q[0][i] !== exp[i]) begin
        nfail++; nbad++;
        if (nbad < 5) $display("FAIL bp_out_data[%0d]: got %h expected %h", i, out_q[0][i], exp[i]);
      end
    end
    bp = 2'b00;
  endtask

  task automatic test_late_arrival();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b01; limit[0] = 1024; limit[1] = 1024; gap = 0;
    repeat (100) step();
    en = 2'b11;
    run_fd(1, 6000);
    nchk++; if (in_q[1].size() != 0 || cnt_irdy[1] != 0) begin
      nfail++; $display("FAIL late_blocked: got %0d beats, %0d ready cycles expected 0", in_q[1].size(), cnt_irdy[1]); end
    run_fd(2, 6000);
    nchk++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      nfail++; $display("FAIL late_grant_seq: got %0d,%0d expected 0,1", grant_log[0], grant_log[1]); end
    if (start_cyc.size() >= 2 && end_cyc.size() >= 1) begin
      nchk++; if (start_cyc[1] != end_cyc[0] + 2) begin
        nfail++; $display("FAIL late_bubble: got %0d expected %0d", start_cyc[1], end_cyc[0] + 2); end
    end
    nchk++; if (in_q[1].size() != 1024 || out_q[1].size() != 256) begin
      nfail++; $display("FAIL late_beats: got %0d/%0d expected 1024/256", in_q[1].size(), out_q[1].size()); end
    exp = decimate(in_q[1]); nbad = 0;
    foreach (exp[i]) if (i < out_q[1].size()) begin
      nchk++;
      if (out_q[1][i] !== exp[i]) begin
        nfail++; nbad++;
        if (nbad < 5) $display("FAIL late_out_data[%0d]: got %h expected %h", i, out_q[1][i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b01; limit[0] = 1024; gap = 0;
    for (int i = 0; i < 4000 && in_q[0].size() < 500; i++) step();
    RESET = 1'b1; en = 2'b00;
    step();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    nchk++; if ({irdy, ovld, ds_in_valid, ds_out_ready} !== 6'b0) begin
      nfail++; $display("FAIL midrst_handshakes: got %b expected 000000", {irdy, ovld, ds_in_valid, ds_out_ready}); end
    nchk++; if (frame_done !== 1'b0 || fd_cyc.size() != 0) begin
      nfail++; $display("FAIL midrst_frame_done: got %b (%0d pulses) expected 0", frame_done, fd_cyc.size()); end
    RESET = 1'b0;
    clear_logs();
    en = 2'b10; limit[1] = 1024;
    run_fd(1, 6000);
    nchk++; if (grant_log.size() != 1 || grant_log[0] != 1) begin
      nfail++; $display("FAIL midrst_grant: got %0d expected 1", grant_log[0]); end
    nchk++; if (in_q[1].size() != 1024 || out_q[1].size() != 256 || fd_cyc.size() != 1) begin
      nfail++; $display("FAIL midrst_frame: got %0d/%0d/%0d expected 1024/256/1", in_q[1].size(), out_q[1].size(), fd_cyc.size()); end
    exp = decimate(in_q[1]); nbad = 0;
    foreach (exp[i]) if (i < out_q[1].size()) begin
      nchk++;
      if (out_q[1][i] !== exp[i]) begin
        nfail++; nbad++;
        if (nbad < 5) $display("FAIL midrst_out_data[%0d]: got %h expected %h", i, out_q[1][i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    pq_t exp;
    int  nbad;
    do_reset();
    en = 2'b01; limit[0] = 2048; gap = 0;
    run_fd(2, 8000);
    nchk++; if (fd_cyc.size() != 2) begin nfail++; $display("FAIL wrap_frames: got %0d expected 2", fd_cyc.size()); end
    nchk++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 0) begin
      nfail++; $display("FAIL wrap_grants: got %0d,%0d expected 0,0", grant_log[0], grant_log[1]); end
    if (start_cyc.size() >= 2 && end_cyc.size() >= 1) begin
      nchk++; if (start_cyc[1] != end_cyc[0] + 2) begin
        nfail++; $display("FAIL wrap_bubble: got %0d expected %0d", start_cyc[1], end_cyc[0] + 2); end
    end
    if (out_q[0].size() > 256 && in_q[0].size() > 1024) begin
      nchk++; if (out_q[0][256] !== in_q[0][1024]) begin
        nfail++; $display("FAIL wrap_first_pixel: got %h expected %h", out_q[0][256], in_q[0][1024]); end
    end
    nchk++; if (in_q[0].size() != 2048 || out_q[0].size() != 512) begin
      nfail++; $display("FAIL wrap_beats: got %0d/%0d expected 2048/512", in_q[0].size(), out_q[0].size()); end
    exp = decimate(in_q[0]); nbad = 0;
    foreach (exp[i]) if (i < out_q[0].size()) begin
      nchk++;
      if (out_q[0][i] !== exp[i]) begin
        nfail++; nbad++;
        if (nbad < 5) $display("FAIL wrap_out_data[%0d]: got %h expected %h", i, out_q[0][i], exp[i]);
      end
    end
  endtask

  initial begin
    nchk = 0; nfail = 0; cyc = 0; busy_prev = 1'b0;
    RESET = 1'b1; vld = 2'b00; rdy = 2'b00; en = 2'b00; bp = 2'b00; gap = 0;
    d[0] = 16'($urandom); d[1] = 16'($urandom);
    limit[0] = 0; limit[1] = 0;
    clear_logs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_late_arrival();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
